// File: rtl/evr_pkg.sv
// ---------------------------------------------------------------------------
// evr_pkg
// Shared definitions for the EVR segmented data-buffer receiver:
//   - default segment size and framing K-characters
//   - dbuf_state_t, the frame parser state enum
//   - cksum_expected(), the checksum a sender appends for a given byte sum
// ---------------------------------------------------------------------------
package evr_pkg;

  localparam int unsigned SEG_BYTES_DEF = 16;
  localparam logic [7:0]  START_K_DEF   = 8'h5C;  // K28.2
  localparam logic [7:0]  STOP_K_DEF    = 8'h3C;  // K28.1

  // One state per sampled byte position of a frame
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_STOP,
    ST_CK_HI,
    ST_CK_LO
  } dbuf_state_t;

  // The sender transmits the ones'-style complement of the 16-bit byte sum
  function automatic logic [15:0] cksum_expected(input logic [15:0] sum);
    return 16'hFFFF - sum;
  endfunction

endpackage

// File: rtl/evr_dbuf_commit.sv
// ---------------------------------------------------------------------------
// evr_dbuf_commit
// Holds one verified segment and writes it to the segment RAM as consecutive
// 32-bit big-endian words, word 0 first, one word per cycle. Because the
// segment is copied into a private holding register at start_i, the parser
// is free to collect the next frame while the writes are still going out.
//
// Ports
//   clk, reset   rx_clk and asynchronous active-high reset
//   start_i      1-cycle request: latch seg_i/data_i and begin writing
//   seg_i        segment number of the verified frame
//   data_i       segment payload, byte 0 in the top byte
//   wr_en_o      RAM write strobe
//   wr_addr_o    {segment, word index}
//   wr_data_o    word being written
//   seg_done_o   high together with the final write of a segment
//   seg_num_o    segment of the last completed commit (updates on final write)
// ---------------------------------------------------------------------------
module evr_dbuf_commit
  import evr_pkg::*;
#(
  parameter int unsigned  SEG_BYTES = SEG_BYTES_DEF,
  localparam int unsigned WORDS     = SEG_BYTES / 4,
  localparam int unsigned WORD_W    = $clog2(WORDS),
  localparam int unsigned DATA_W    = SEG_BYTES * 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  input  logic [7:0]          seg_i,
  input  logic [DATA_W-1:0]   data_i,
  output logic                wr_en_o,
  output logic [8+WORD_W-1:0] wr_addr_o,
  output logic [31:0]         wr_data_o,
  output logic                seg_done_o,
  output logic [7:0]          seg_num_o
);

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS - 1);

  logic              active_q, active_d;
  logic [WORD_W-1:0] word_q,   word_d;
  logic [7:0]        hSeg_q,   hSeg_d;
  logic [DATA_W-1:0] hData_q,  hData_d;
  logic [7:0]        segNum_q, segNum_d;
  logic              lastWord;
  logic [31:0]       words [WORDS];

  assign lastWord = active_q && (word_q == LAST_WORD);

  // Split the held segment into big-endian words for indexing by word_q
  always_comb begin
    for (int k = 0; k < WORDS; k++) begin
      words[k] = hData_q[DATA_W-1-32*k -: 32];
    end
  end

  // Advance through the words; a new start reloads the holding register
  always_comb begin
    active_d = active_q;
    word_d   = word_q;
    hSeg_d   = hSeg_q;
    hData_d  = hData_q;
    segNum_d = segNum_q;
    if (active_q) begin
      word_d = word_q + WORD_W'(1);
      if (lastWord) begin
        active_d = 1'b0;
        segNum_d = hSeg_q;
      end
    end
    if (start_i) begin
      active_d = 1'b1;
      word_d   = '0;
      hSeg_d   = seg_i;
      hData_d  = data_i;
    end
  end

  // Asynchronous reset abandons any remaining writes immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      word_q   <= '0;
      hSeg_q   <= '0;
      hData_q  <= '0;
      segNum_q <= '0;
    end else begin
      active_q <= active_d;
      word_q   <= word_d;
      hSeg_q   <= hSeg_d;
      hData_q  <= hData_d;
      segNum_q <= segNum_d;
    end
  end

  assign wr_en_o    = active_q;
  assign wr_addr_o  = {hSeg_q, word_q};
  assign wr_data_o  = words[word_q];
  assign seg_done_o = lastWord;
  // seg_num must already show the new segment during the final write
  assign seg_num_o  = lastWord ? hSeg_q : segNum_q;

endmodule

// File: rtl/evr_dbuf_rx.sv
// ---------------------------------------------------------------------------
// evr_dbuf_rx
// EVR segmented data-buffer receiver in the GTP rx_clk domain. Buffer bytes
// share rx_data[7:0] with the dbus, appearing on every second cycle after a
// start symbol. Frames are: START_K, segment address, SEG_BYTES data bytes,
// STOP_K, 16-bit checksum (MSB first). Frames whose checksum matches are
// handed to evr_dbuf_commit, which writes them to the segment RAM.
//
// Ports
//   clk, reset      rx_clk and asynchronous active-high reset
//   rx_valid        link usable (reset done and aligned)
//   rx_data         [7:0] buffer/dbus lane, [15:8] event lane (unused here)
//   rx_is_k         [0] marks rx_data[7:0] as a K-character
//   rx_err          disparity / not-in-table error on the current word
//   wr_en, wr_addr, wr_data   segment RAM write port, wr_addr = {seg, word}
//   seg_done        pulse with the final write of a segment
//   seg_num         segment of the last committed frame
//   frames_ok       good frames (saturating)
//   cksum_err_cnt   checksum mismatches (saturating)
//   frame_err_cnt   framing/symbol errors (saturating)
// ---------------------------------------------------------------------------
module evr_dbuf_rx
  import evr_pkg::*;
#(
  parameter int unsigned  SEG_BYTES = SEG_BYTES_DEF,
  parameter int unsigned  CNT_W     = 16,
  parameter logic [7:0]   START_K   = START_K_DEF,
  parameter logic [7:0]   STOP_K    = STOP_K_DEF,
  localparam int unsigned WORD_W    = $clog2(SEG_BYTES / 4)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_valid,
  input  logic [15:0]         rx_data,
  input  logic [1:0]          rx_is_k,
  input  logic                rx_err,
  output logic                wr_en,
  output logic [8+WORD_W-1:0] wr_addr,
  output logic [31:0]         wr_data,
  output logic                seg_done,
  output logic [7:0]          seg_num,
  output logic [CNT_W-1:0]    frames_ok,
  output logic [CNT_W-1:0]    cksum_err_cnt,
  output logic [CNT_W-1:0]    frame_err_cnt
);

  localparam int unsigned      IDX_W    = $clog2(SEG_BYTES);
  localparam int unsigned      DATA_W   = SEG_BYTES * 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEG_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  dbuf_state_t       state_q, state_d;
  logic              slot_q,  slot_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [15:0]       sum_q,   sum_d;
  logic [7:0]        addr_q,  addr_d;
  logic [7:0]        ckHi_q,  ckHi_d;
  logic [7:0]        data_q [SEG_BYTES];
  logic [7:0]        data_d [SEG_BYTES];
  logic [CNT_W-1:0]  okCnt_q,    okCnt_d;
  logic [CNT_W-1:0]  ckErrCnt_q, ckErrCnt_d;
  logic [CNT_W-1:0]  frErrCnt_q, frErrCnt_d;

  logic [7:0]        rxByte;
  logic              rxK;
  logic              isStart;
  logic              sample;
  logic              symErr;
  logic              frameErr;
  logic              sampleOk;
  logic              ckMatch;
  logic              commitStart;
  logic [DATA_W-1:0] segBus;
  logic              unusedLane;

  assign rxByte     = rx_data[7:0];
  assign rxK        = rx_is_k[0];
  assign unusedLane = ^{rx_data[15:8], rx_is_k[1]};

  // Start is only looked for in IDLE; there every cycle is a candidate
  assign isStart  = rx_valid && rxK && (rxByte == START_K);
  // Inside a frame only slot 0 cycles carry buffer bytes
  assign sample   = (state_q != ST_IDLE) && !slot_q && rx_valid;
  assign frameErr = sample && symErr;
  assign sampleOk = sample && !symErr;
  assign ckMatch  = ({ckHi_q, rxByte} == cksum_expected(sum_q));

  // Decide whether the current sampled byte breaks framing. Only STOP may be
  // a K-character; a START_K mid-frame is just another illegal K here.
  always_comb begin
    symErr = rx_err;
    unique case (state_q)
      ST_ADDR, ST_DATA, ST_CK_HI, ST_CK_LO: if (rxK) symErr = 1'b1;
      ST_STOP: if (!(rxK && (rxByte == STOP_K))) symErr = 1'b1;
      default: symErr = 1'b0;
    endcase
  end

  // Parser state register and lane-phase toggle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      slot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  // Next state: loss of link or any framing error drops back to IDLE at
  // once; otherwise advance one position per good sampled byte
  always_comb begin
    state_d = state_q;
    slot_d  = ~slot_q;
    if (state_q == ST_IDLE) begin
      slot_d = isStart;
      if (isStart) state_d = ST_ADDR;
    end else if (!rx_valid || frameErr) begin
      state_d = ST_IDLE;
    end else if (sampleOk) begin
      unique case (state_q)
        ST_ADDR:  state_d = ST_DATA;
        ST_DATA:  if (idx_q == LAST_IDX) state_d = ST_STOP;
        ST_STOP:  state_d = ST_CK_HI;
        ST_CK_HI: state_d = ST_CK_LO;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Per-state datapath: capture address/data/checksum, accumulate the sum,
  // bump counters and request a commit on a matching checksum
  always_comb begin
    idx_d       = idx_q;
    sum_d       = sum_q;
    addr_d      = addr_q;
    ckHi_d      = ckHi_q;
    data_d      = data_q;
    okCnt_d     = okCnt_q;
    ckErrCnt_d  = ckErrCnt_q;
    frErrCnt_d  = frErrCnt_q;
    commitStart = 1'b0;
    if (frameErr) frErrCnt_d = sat_inc(frErrCnt_q);
    if (sampleOk) begin
      unique case (state_q)
        ST_ADDR: begin
          addr_d = rxByte;
          sum_d  = {8'h00, rxByte};
          idx_d  = '0;
        end
        ST_DATA: begin
          data_d[idx_q] = rxByte;
          sum_d         = sum_q + {8'h00, rxByte};
          idx_d         = idx_q + IDX_W'(1);
        end
        ST_CK_HI: ckHi_d = rxByte;
        ST_CK_LO: begin
          if (ckMatch) begin
            okCnt_d     = sat_inc(okCnt_q);
            commitStart = 1'b1;
          end else begin
            ckErrCnt_d  = sat_inc(ckErrCnt_q);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q      <= '0;
      sum_q      <= '0;
      addr_q     <= '0;
      ckHi_q     <= '0;
      okCnt_q    <= '0;
      ckErrCnt_q <= '0;
      frErrCnt_q <= '0;
      for (int k = 0; k < SEG_BYTES; k++) data_q[k] <= '0;
    end else begin
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      addr_q     <= addr_d;
      ckHi_q     <= ckHi_d;
      okCnt_q    <= okCnt_d;
      ckErrCnt_q <= ckErrCnt_d;
      frErrCnt_q <= frErrCnt_d;
      data_q     <= data_d;
    end
  end

  // Byte 0 lands in the top byte so words come out big-endian
  always_comb begin
    for (int k = 0; k < SEG_BYTES; k++) begin
      segBus[DATA_W-1-8*k -: 8] = data_q[k];
    end
  end

  evr_dbuf_commit #(
    .SEG_BYTES (SEG_BYTES)
  ) uCommit (
    .clk        (clk),
    .reset      (reset),
    .start_i    (commitStart),
    .seg_i      (addr_q),
    .data_i     (segBus),
    .wr_en_o    (wr_en),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .seg_done_o (seg_done),
    .seg_num_o  (seg_num)
  );

  assign frames_ok     = okCnt_q;
  assign cksum_err_cnt = ckErrCnt_q;
  assign frame_err_cnt = frErrCnt_q;

endmodule

// File: tb/tb_evr_dbuf_rx.sv
// ---------------------------------------------------------------------------
// tb_evr_dbuf_rx
// Drives directed and random frames into evr_dbuf_rx and compares the RAM
// writes and status counters with a frame-level reference model. Counters
// are built 4 bits wide here so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_evr_dbuf_rx;

  localparam int SEG   = 16;
  localparam int CW    = 4;
  localparam int WORDS = SEG / 4;
  localparam int AW    = 8 + $clog2(WORDS);
  localparam int NSYM  = SEG + 4;

  localparam int FT_NONE      = 0;
  localparam int FT_CK        = 1;
  localparam int FT_K         = 2;
  localparam int FT_STOP_DATA = 3;
  localparam int FT_STOP_BYTE = 4;
  localparam int FT_ERR       = 5;
  localparam int FT_DROP      = 6;
  localparam int FT_START     = 7;

  localparam int OUT_OK   = 0;
  localparam int OUT_CK   = 1;
  localparam int OUT_FE   = 2;
  localparam int OUT_DROP = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [15:0]   rx_data;
  logic [1:0]    rx_is_k;
  logic          rx_err;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          seg_done;
  logic [7:0]    seg_num;
  logic [CW-1:0] frames_ok;
  logic [CW-1:0] cksum_err_cnt;
  logic [CW-1:0] frame_err_cnt;

  evr_dbuf_rx #(
    .SEG_BYTES (SEG),
    .CNT_W     (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_is_k       (rx_is_k),
    .rx_err        (rx_err),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .seg_done      (seg_done),
    .seg_num       (seg_num),
    .frames_ok     (frames_ok),
    .cksum_err_cnt (cksum_err_cnt),
    .frame_err_cnt (frame_err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          done;
    int            cyc;
  } wr_t;

  wr_t        expQ[$];
  logic [7:0] fAddr;
  logic [7:0] fData [SEG];
  int         mOk = 0, mCk = 0, mFe = 0;
  int         vectors = 0, miscompares = 0;

  // Every comparison of the bench funnels through here
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int satInc(input int v);
    return (v >= (1 << CW) - 1) ? v : v + 1;
  endfunction

  // Present one lane word for one cycle
  task automatic applyStimulus(input logic v, input logic [7:0] b,
                               input logic k, input logic e);
    rx_valid = v;
    rx_data  = {8'($urandom), b};
    rx_is_k  = {1'($urandom), k};
    rx_err   = e;
    @(negedge clk);
  endtask

  // Interleaved dbus cycle inside a frame: content is irrelevant to the buffer
  task automatic dbusCycle();
    applyStimulus(1'b1, 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Idle noise between frames that never looks like a start symbol
  task automatic idleCycle();
    logic [7:0] b;
    logic       k;
    b = 8'($urandom);
    k = 1'($urandom);
    if (b == 8'h5C) k = 1'b0;
    applyStimulus(1'($urandom), b, k, 1'($urandom));
  endtask

  task automatic checkCounters(input string when);
    checkOutput({when, ".frames_ok"}, frames_ok, mOk);
    checkOutput({when, ".cksum_err"}, cksum_err_cnt, mCk);
    checkOutput({when, ".frame_err"}, frame_err_cnt, mFe);
  endtask

  // Send the frame in fAddr/fData with an optional fault, update the model
  // from the symbols actually sent, then idle for 'gap' cycles
  task automatic sendFrame(input int fault, input int posIn, input int gap);
    logic [7:0]  sb [NSYM];
    logic        sk [NSYM];
    logic        se [NSYM];
    logic [15:0] sum;
    logic        bad;
    int          pos, dropAt, last, outcome;

    sum = 16'(fAddr);
    for (int i = 0; i < SEG; i++) sum = sum + 16'(fData[i]);
    for (int i = 0; i < NSYM; i++) begin
      sk[i] = 1'b0;
      se[i] = 1'b0;
    end
    sb[0] = fAddr;
    for (int i = 0; i < SEG; i++) sb[1+i] = fData[i];
    sb[SEG+1] = 8'h3C;
    sk[SEG+1] = 1'b1;
    sb[SEG+2] = 8'((16'hFFFF - sum) >> 8);
    sb[SEG+3] = 8'(16'hFFFF - sum);

    dropAt = -1;
    pos    = (posIn < 0) ? $urandom_range(NSYM - 1, 0) : posIn;
    case (fault)
      FT_CK:        sb[SEG+3] = sb[SEG+3] ^ 8'($urandom_range(255, 1));
      FT_K: begin
        if (pos == SEG + 1) pos = 0;
        sk[pos] = 1'b1;
        sb[pos] = 8'($urandom);
      end
      FT_STOP_DATA: sk[SEG+1] = 1'b0;
      FT_STOP_BYTE: sb[SEG+1] = sb[SEG+1] ^ 8'($urandom_range(255, 1));
      FT_ERR:       se[pos] = 1'b1;
      FT_DROP:      dropAt = pos;
      FT_START: begin
        pos     = 1 + (pos % SEG);
        sb[pos] = 8'h5C;
        sk[pos] = 1'b1;
      end
      default: ;
    endcase

    // Reference model: walk the frame's byte positions against the rules
    outcome = OUT_OK;
    last    = NSYM - 1;
    for (int p = 0; p < NSYM; p++) begin
      if (p == dropAt) begin
        outcome = OUT_DROP;
        last    = p;
        break;
      end
      bad = se[p] || ((p == SEG + 1) ? !(sk[p] && sb[p] == 8'h3C) : sk[p]);
      if (bad) begin
        outcome = OUT_FE;
        last    = p;
        break;
      end
    end
    if (outcome == OUT_OK) begin
      sum = 16'(sb[0]);
      for (int i = 1; i <= SEG; i++) sum = sum + 16'(sb[i]);
      if ({sb[SEG+2], sb[SEG+3]} != 16'hFFFF - sum) outcome = OUT_CK;
    end

    applyStimulus(1'b1, 8'h5C, 1'b1, 1'b0);
    for (int p = 0; p <= last; p++) begin
      if (p == dropAt) begin
        applyStimulus(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
        break;
      end
      dbusCycle();
      if (p == NSYM - 1 && outcome == OUT_OK) begin
        for (int w = 0; w < WORDS; w++) begin
          wr_t e;
          e.addr = {sb[0], 2'(w)};
          e.data = {sb[1+4*w], sb[2+4*w], sb[3+4*w], sb[4+4*w]};
          e.done = (w == WORDS - 1);
          e.cyc  = cyc + 1 + w;
          expQ.push_back(e);
        end
      end
      applyStimulus(1'b1, sb[p], sk[p], se[p]);
    end

    case (outcome)
      OUT_OK:  mOk = satInc(mOk);
      OUT_CK:  mCk = satInc(mCk);
      OUT_FE:  mFe = satInc(mFe);
      default: ;
    endcase
    checkCounters("frame");
    for (int g = 0; g < gap; g++) idleCycle();
  endtask

  task automatic loadRandom();
    fAddr = 8'($urandom);
    for (int i = 0; i < SEG; i++) fData[i] = 8'($urandom);
  endtask

  task automatic checkResetState(input string when);
    checkOutput({when, ".wr_en"}, wr_en, 0);
    checkOutput({when, ".wr_addr"}, wr_addr, 0);
    checkOutput({when, ".wr_data"}, wr_data, 0);
    checkOutput({when, ".seg_done"}, seg_done, 0);
    checkOutput({when, ".seg_num"}, seg_num, 0);
    checkCounters(when);
  endtask

  // Write monitor: every write must match the next expected one, on time
  always @(negedge clk) begin
    wr_t e;
    if (!reset && wr_en) begin
      if (expQ.size() == 0) begin
        checkOutput("wr_unexpected", wr_addr, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("wr_addr", wr_addr, e.addr);
        checkOutput("wr_data", wr_data, e.data);
        checkOutput("seg_done", seg_done, e.done);
        checkOutput("wr_cycle", cyc, e.cyc);
        if (e.done) checkOutput("seg_num", seg_num, e.addr[AW-1:2]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic found;

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    rx_is_k  = '0;
    rx_err   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkResetState("reset");
    reset = 1'b0;
    @(negedge clk);

    // Directed frame with a known checksum F7D9
    fAddr = 8'h04;
    for (int i = 0; i < SEG; i++) begin
      case (i % 8)
        0, 2, 7: fData[i] = 8'hAD;
        1, 3, 6: fData[i] = 8'h74;
        4:       fData[i] = 8'h7A;
        default: fData[i] = 8'h34;
      endcase
    end
    sendFrame(FT_NONE, 0, 6);

    // Directed frame to segment FF, checksum FCF0, then with a bad checksum
    fAddr = 8'hFF;
    for (int i = 0; i < SEG; i++) fData[i] = 8'h00;
    fData[1] = 8'h8B; fData[2] = 8'hFC; fData[3] = 8'h7B;
    fData[7] = 8'h07; fData[15] = 8'h07;
    sendFrame(FT_NONE, 0, 6);
    sendFrame(FT_CK, 0, 3);

    // Stop symbol sent as data, then a link drop at data byte 5
    loadRandom();
    sendFrame(FT_STOP_DATA, 0, 2);
    loadRandom();
    sendFrame(FT_DROP, 6, 2);
    loadRandom();
    sendFrame(FT_NONE, 0, 0);

    // Back-to-back good frames at minimum spacing
    loadRandom();
    sendFrame(FT_NONE, 0, 0);
    loadRandom();
    sendFrame(FT_NONE, 0, 0);

    // Randomized mix of good and faulty frames
    for (int n = 0; n < 60; n++) begin
      loadRandom();
      sendFrame(($urandom_range(1, 0) == 0) ? FT_NONE : $urandom_range(7, 1), -1,
                $urandom_range(3, 0));
    end

    // Enough framing errors to hold the counter at saturation
    for (int n = 0; n < 18; n++) begin
      loadRandom();
      sendFrame(FT_K, 0, $urandom_range(2, 0));
    end
    for (int n = 0; n < 18; n++) begin
      loadRandom();
      sendFrame(FT_CK, 0, 0);
    end

    // Asynchronous reset during the second write of a commit
    loadRandom();
    sendFrame(FT_NONE, 0, 0);
    rx_valid = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (wr_en && wr_addr[1:0] == 2'd1) found = 1'b1;
    end
    checkOutput("reset_wait_word1", found, 1);
    #2;
    reset = 1'b1;
    #1;
    expQ.delete();
    mOk = 0;
    mCk = 0;
    mFe = 0;
    checkResetState("midreset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    loadRandom();
    sendFrame(FT_NONE, 0, 0);
    for (int i = 0; i < 10; i++) idleCycle();
    checkOutput("pending_writes", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
